clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Clock/date/alarm set-mode controller: button-driven BCD editing with commit strobes.
// Optional idle abort is compiled in when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic        mclk_i,
    input  logic        rst_i,
    input  logic        sec_tick_i,
    input  logic        btn_mode_i,
    input  logic        btn_sel_i,
    input  logic        btn_inc_i,
    input  logic [23:0] cur_time_i,
    input  logic [2:0]  cur_weekday_i,
    input  logic [15:0] cur_year_i,
    output logic [1:0]  clk_mode_o,
    output logic [1:0]  field_o,
    output logic [23:0] edit_time_o,
    output logic [2:0]  edit_weekday_o,
    output logic [15:0] edit_year_o,
    output logic [15:0] edit_alarm_o,
    output logic        time_load_o,
    output logic        date_load_o,
    output logic        alarm_load_o,
    output logic        blink_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_TIME  = 2'd1,
        SET_DATE  = 2'd2,
        SET_ALARM = 2'd3
    } state_e;

    state_e      state_q;
    logic [1:0]  field_q;
    logic [23:0] edit_time_q;
    logic [2:0]  edit_weekday_q;
    logic [15:0] edit_year_q;
    logic [15:0] edit_alarm_q;
    logic        time_load_q;
    logic        date_load_q;
    logic        alarm_load_q;
    logic        blink_q;

    logic [23:0] edit_time_d;
    logic [2:0]  edit_weekday_d;
    logic [15:0] edit_year_d;
    logic [15:0] edit_alarm_d;
    logic        any_btn;
    logic        timeout_fire;
    logic        to_idle;

    // Two-digit BCD increment; lim is the last legal value before wrapping to 00.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v >= lim)
            r = 8'h00;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic        carry;
        logic [15:0] r;
        carry = 1'b1;
        r     = v;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (v[4*k +: 4] >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Increment candidates for the field under the cursor; applied only on an accepted btn_inc.
    always_comb begin
        edit_time_d    = edit_time_q;
        edit_weekday_d = edit_weekday_q;
        edit_year_d    = edit_year_q;
        edit_alarm_d   = edit_alarm_q;
        case (state_q)
            SET_TIME: begin
                case (field_q)
                    2'd0:    edit_time_d[23:16] = bcd2_inc(edit_time_q[23:16], 8'h23);
                    2'd1:    edit_time_d[15:8]  = bcd2_inc(edit_time_q[15:8], 8'h59);
                    default: edit_time_d[7:0]   = 8'h00;
                endcase
            end
            SET_DATE: begin
                if (field_q == 2'd0)
                    edit_weekday_d = (edit_weekday_q >= 3'd6) ? 3'd0 : edit_weekday_q + 3'd1;
                else
                    edit_year_d = bcd4_inc(edit_year_q);
            end
            SET_ALARM: begin
                if (field_q == 2'd0)
                    edit_alarm_d[15:8] = bcd2_inc(edit_alarm_q[15:8], 8'h23);
                else
                    edit_alarm_d[7:0]  = bcd2_inc(edit_alarm_q[7:0], 8'h59);
            end
            default: ;
        endcase
    end

    assign any_btn = btn_mode_i | btn_sel_i | btn_inc_i;

`ifdef CLOCK_SET_TIMEOUT_EN
    logic [7:0] idle_cnt_q;

    // A button in the same cycle as the final tick restarts the count instead of aborting.
    assign timeout_fire = (state_q != IDLE) && !any_btn && sec_tick_i &&
                          ({1'b0, idle_cnt_q} + 9'd1 >= 9'(TIMEOUT_S));

    always_ff @(posedge mclk_i) begin
        if (!rst_i)
            idle_cnt_q <= 8'd0;
        else if (state_q == IDLE || any_btn || timeout_fire)
            idle_cnt_q <= 8'd0;
        else if (sec_tick_i)
            idle_cnt_q <= idle_cnt_q + 8'd1;
    end
`else
    assign timeout_fire = 1'b0;
    if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : g_timeout_unused
    end
`endif

    assign to_idle = (btn_mode_i && state_q == SET_ALARM) || timeout_fire;

    always_ff @(posedge mclk_i) begin
        if (!rst_i) begin
            state_q        <= IDLE;
            field_q        <= 2'd0;
            edit_time_q    <= 24'h000000;
            edit_weekday_q <= 3'd0;
            edit_year_q    <= 16'h2024;
            edit_alarm_q   <= 16'h0000;
            time_load_q    <= 1'b0;
            date_load_q    <= 1'b0;
            alarm_load_q   <= 1'b0;
            blink_q        <= 1'b0;
        end else begin
            time_load_q  <= 1'b0;
            date_load_q  <= 1'b0;
            alarm_load_q <= 1'b0;
            if (btn_mode_i) begin
                field_q <= 2'd0;
                case (state_q)
                    IDLE: begin
                        state_q     <= SET_TIME;
                        edit_time_q <= cur_time_i;
                    end
                    SET_TIME: begin
                        state_q        <= SET_DATE;
                        time_load_q    <= 1'b1;
                        edit_weekday_q <= cur_weekday_i;
                        edit_year_q    <= cur_year_i;
                    end
                    SET_DATE: begin
                        state_q     <= SET_ALARM;
                        date_load_q <= 1'b1;
                    end
                    default: begin
                        state_q      <= IDLE;
                        alarm_load_q <= 1'b1;
                    end
                endcase
            end else if (state_q != IDLE) begin
                if (btn_sel_i) begin
                    if (field_q == ((state_q == SET_TIME) ? 2'd2 : 2'd1))
                        field_q <= 2'd0;
                    else
                        field_q <= field_q + 2'd1;
                end else if (btn_inc_i) begin
                    edit_time_q    <= edit_time_d;
                    edit_weekday_q <= edit_weekday_d;
                    edit_year_q    <= edit_year_d;
                    edit_alarm_q   <= edit_alarm_d;
                end else if (timeout_fire) begin
                    state_q <= IDLE;
                    field_q <= 2'd0;
                end
            end

            if (to_idle || state_q == IDLE)
                blink_q <= 1'b0;
            else if (sec_tick_i)
                blink_q <= ~blink_q;
        end
    end

    assign clk_mode_o     = state_q;
    assign field_o        = field_q;
    assign edit_time_o    = edit_time_q;
    assign edit_weekday_o = edit_weekday_q;
    assign edit_year_o    = edit_year_q;
    assign edit_alarm_o   = edit_alarm_q;
    assign time_load_o    = time_load_q;
    assign date_load_o    = date_load_q;
    assign alarm_load_o   = alarm_load_q;
    assign blink_o        = blink_q;

endmodule
